// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the two-layer MNIST inference datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Holds the network geometry (784 -> 200 -> 10), datapath word widths, the
// weight1 address width and the sequencer state encoding used by
// nn_layer_sequencer and nn_seq_counter.
package nn_pkg;

    // Network geometry
    localparam int N_IN  = 784;     // pixels per image
    localparam int N_HID = 200;     // hidden neurons
    localparam int N_OUT = 10;      // output classes / weight2 row length

    // Datapath word widths
    localparam int PIX_W = 9;
    localparam int W1_W  = 9;
    localparam int W2_W  = 16;

    // Address / index widths
    localparam int W1_AW = 18;      // covers N_IN*N_HID = 156800
    localparam int IN_AW = 10;      // input-SRAM address (pixel index j)
    localparam int HID_W = 8;       // hidden neuron index i

    // Sequencer states, kept as plain constants so older tools and scripts
    // can match on the raw encoding.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_L1_MAC  = 3'd1;
    localparam logic [2:0] S_L1_ACT  = 3'd2;
    localparam logic [2:0] S_W2_WAIT = 3'd3;
    localparam logic [2:0] S_L2_MAC  = 3'd4;
    localparam logic [2:0] S_OUT_ACT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_L1_MAC  = S_L1_MAC,
        ST_L1_ACT  = S_L1_ACT,
        ST_W2_WAIT = S_W2_WAIT,
        ST_L2_MAC  = S_L2_MAC,
        ST_OUT_ACT = S_OUT_ACT
    } nn_state_e;

endpackage

// File: rtl/nn_seq_counter.sv
// Loop counter group for the layer sequencer: pixel index j, weight1 address, hidden index i.
// Latency: counters update on the clock edge following clr_i / j_inc_i / i_inc_i.
// Backpressure: none; the caller simply withholds j_inc_i while the weight1 stream stalls.
//
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   clr_i         zero all three counters (start of an inference)
//   j_inc_i       one weight1 word consumed: advance j (wrapping) and w1_addr
//   i_inc_i       advance to the next hidden neuron
//   j_o           pixel index j
//   w1_addr_o     running weight1 address i*N_IN + j
//   i_o           hidden neuron index i
//   j_last_o      j is at N_IN-1
//   i_last_o      i is at N_HID-1
module nn_seq_counter
    import nn_pkg::*;
#(
    parameter int N_IN  = nn_pkg::N_IN,
    parameter int N_HID = nn_pkg::N_HID,
    parameter int W1_AW = nn_pkg::W1_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             j_inc_i,
    input  logic             i_inc_i,
    output logic [IN_AW-1:0] j_o,
    output logic [W1_AW-1:0] w1_addr_o,
    output logic [HID_W-1:0] i_o,
    output logic             j_last_o,
    output logic             i_last_o
);

    logic [IN_AW-1:0] j_q, j_d;
    logic [W1_AW-1:0] w1_addr_q, w1_addr_d;
    logic [HID_W-1:0] i_q, i_d;

    assign j_last_o = (j_q == IN_AW'(N_IN - 1));
    assign i_last_o = (i_q == HID_W'(N_HID - 1));

    // w1_addr is never reset at a neuron boundary: it keeps counting through
    // the j wrap, so it always equals i*N_IN + j without a multiplier.
    always_comb begin
        j_d       = j_q;
        w1_addr_d = w1_addr_q;
        i_d       = i_q;
        if (clr_i) begin
            j_d       = '0;
            w1_addr_d = '0;
            i_d       = '0;
        end else begin
            if (j_inc_i) begin
                j_d       = j_last_o ? '0 : j_q + IN_AW'(1);
                w1_addr_d = w1_addr_q + W1_AW'(1);
            end
            if (i_inc_i) begin
                i_d = i_q + HID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j_q       <= '0;
            w1_addr_q <= '0;
            i_q       <= '0;
        end else begin
            j_q       <= j_d;
            w1_addr_q <= w1_addr_d;
            i_q       <= i_d;
        end
    end

    assign j_o       = j_q;
    assign w1_addr_o = w1_addr_q;
    assign i_o       = i_q;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Central controller for the two-layer MNIST datapath: walks pixels per hidden neuron, drives MAC/activation strobes.
// Latency: N_IN+2 cycles per hidden neuron without stalls; done pulses two cycles after the last L2_MAC.
// Backpressure: stalls in L1_MAC while w1_valid=0 and in W2_WAIT until the weight2 row for the neuron arrives.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   start              begin one inference (only sampled in IDLE)
//   busy, done         status; done is a one-cycle pulse in the first IDLE cycle
//   in_addr, w1_addr   pixel index j and weight1 address i*N_IN+j
//   w1_valid           off-chip weight1 word present this cycle
//   mac1_clr, mac1_en  layer-1 accumulator clear / accumulate
//   act1_en, hid_idx   hidden activation strobe and current hidden neuron i
//   w2_load_next_row   request for weight2 row i; w2_row_ready reports arrival
//   mac2_clr, mac2_en  layer-2 accumulator clear / accumulate
//   out_act_en         final activation/argmax strobe
//   stall_cycles       (only with NNSEQ_PERF_CNT_EN) saturating stall-cycle counter
//
// Build option: define NNSEQ_PERF_CNT_EN to add the stall_cycles counter.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN  = nn_pkg::N_IN,
    parameter int N_HID = nn_pkg::N_HID,
    parameter int W1_AW = nn_pkg::W1_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IN_AW-1:0] in_addr,
    output logic [W1_AW-1:0] w1_addr,
    input  logic             w1_valid,
    output logic             mac1_clr,
    output logic             mac1_en,
    output logic             act1_en,
    output logic [HID_W-1:0] hid_idx,
    output logic             w2_load_next_row,
    input  logic             w2_row_ready,
    output logic             mac2_clr,
    output logic             mac2_en,
`ifdef NNSEQ_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic             out_act_en
);

    nn_state_e state_q, state_d;
    logic      w2_have_q, w2_have_d;    // weight2 row for the current neuron is in SRAM
    logic      first_q, first_d;        // first cycle of this neuron's L1_MAC
    logic      done_q, done_d;

    logic      start_acc;
    logic      l1_word;
    logic      in_l2;
    logic      j_last, i_last;

    // start is honoured only in IDLE; masking with reset keeps the clear
    // strobes quiet while reset is held.
    assign start_acc = (state_q == ST_IDLE) && start && !reset;
    assign l1_word   = (state_q == ST_L1_MAC) && w1_valid;
    assign in_l2     = (state_q == ST_L2_MAC);

    nn_seq_counter #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .W1_AW (W1_AW)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (start_acc),
        .j_inc_i   (l1_word),
        .i_inc_i   (in_l2 && !i_last),
        .j_o       (in_addr),
        .w1_addr_o (w1_addr),
        .i_o       (hid_idx),
        .j_last_o  (j_last),
        .i_last_o  (i_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_acc) state_d = ST_L1_MAC;
            ST_L1_MAC:  if (w1_valid && j_last) state_d = ST_L1_ACT;
            ST_L1_ACT:  state_d = w2_have_q ? ST_L2_MAC : ST_W2_WAIT;
            // Leave on the arrival pulse itself so mac2_en lands in the very
            // next cycle rather than waiting for the flag to register.
            ST_W2_WAIT: if (w2_have_q || w2_row_ready) state_d = ST_L2_MAC;
            ST_L2_MAC:  state_d = i_last ? ST_OUT_ACT : ST_L1_MAC;
            ST_OUT_ACT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Row arrival sets the flag and beats the clear from L2_MAC; a duplicate
    // arrival while already set leaves it set. Arrivals in IDLE are dropped.
    always_comb begin
        if (state_q == ST_IDLE) begin
            w2_have_d = 1'b0;
        end else if (w2_row_ready) begin
            w2_have_d = 1'b1;
        end else if (in_l2) begin
            w2_have_d = 1'b0;
        end else begin
            w2_have_d = w2_have_q;
        end
    end

    // Marks the entry cycle of L1_MAC (from IDLE or L2_MAC) so the weight2
    // request fires exactly once per neuron even if that cycle is stalled.
    assign first_d = (state_d == ST_L1_MAC) && (state_q != ST_L1_MAC);
    assign done_d  = (state_q == ST_OUT_ACT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            w2_have_q <= 1'b0;
            first_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w2_have_q <= w2_have_d;
            first_q   <= first_d;
            done_q    <= done_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign mac1_en          = l1_word;
    assign mac1_clr         = start_acc || (in_l2 && !i_last);
    assign mac2_clr         = start_acc;
    assign act1_en          = (state_q == ST_L1_ACT);
    assign w2_load_next_row = (state_q == ST_L1_MAC) && first_q;
    assign mac2_en          = in_l2;
    assign out_act_en       = (state_q == ST_OUT_ACT);

`ifdef NNSEQ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_evt;

    assign stall_evt = ((state_q == ST_L1_MAC) && !w1_valid) || (state_q == ST_W2_WAIT);

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer using a reduced geometry (12 pixels, 6 hidden neurons).
// Latency: expected outputs come from a per-inference timeline computed from the planned stimulus.
// Backpressure: weight1 stalls and weight2 arrival delays are planned per neuron and replayed cycle by cycle.
module tb_nn_layer_sequencer;

    localparam int NI    = 12;
    localparam int NH    = 6;
    localparam int AW    = 18;
    localparam int MAXL  = NI + 8;
    localparam int OBS_W = 9 + 10 + AW + 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          w1_valid = 1'b0;
    logic          w2_row_ready = 1'b0;
    logic          busy, done, mac1_clr, mac1_en, act1_en;
    logic          w2_load_next_row, mac2_clr, mac2_en, out_act_en;
    logic [9:0]    in_addr;
    logic [AW-1:0] w1_addr;
    logic [7:0]    hid_idx;
`ifdef NNSEQ_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    nn_layer_sequencer #(.N_IN(NI), .N_HID(NH), .W1_AW(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .in_addr          (in_addr),
        .w1_addr          (w1_addr),
        .w1_valid         (w1_valid),
        .mac1_clr         (mac1_clr),
        .mac1_en          (mac1_en),
        .act1_en          (act1_en),
        .hid_idx          (hid_idx),
        .w2_load_next_row (w2_load_next_row),
        .w2_row_ready     (w2_row_ready),
        .mac2_clr         (mac2_clr),
        .mac2_en          (mac2_en),
`ifdef NNSEQ_PERF_CNT_EN
        .stall_cycles     (stall_cycles),
`endif
        .out_act_en       (out_act_en)
    );

    always #5 clk = ~clk;

    logic [OBS_W-1:0] obs;
    assign obs = {busy, done, mac1_clr, mac1_en, act1_en, w2_load_next_row,
                  mac2_clr, mac2_en, out_act_en, in_addr, w1_addr, hid_idx};

    int vectors = 0;
    int miscompares = 0;

    // Stimulus plan: per neuron, the w1_valid pattern over its L1 window
    // (NI ones plus s_cnt zeros, never ending on a zero), the delay from the
    // weight2 request to its arrival pulse, and whether a duplicate pulse follows.
    int  s_cnt  [NH];
    bit  vplan  [NH][MAXL];
    int  dly    [NH];
    bit  dup_en [NH];
    bit  rand_start;

    // Timeline derived from the plan (cycle 0 = start accepted).
    int  S [NH];    // first L1 cycle
    int  A [NH];    // hidden activation cycle
    int  R [NH];    // weight2 arrival pulse
    int  L2[NH];    // layer-2 accumulate cycle
    int  t_out, t_done, exp_stalls;

    // Counter values visible while idle before the next start.
    int  idle_w1  = 0;
    int  idle_hid = 0;

    task automatic plan_clear();
        for (int n = 0; n < NH; n++) begin
            s_cnt[n]  = 0;
            dly[n]    = 5;
            dup_en[n] = 1'b0;
            for (int k = 0; k < MAXL; k++) vplan[n][k] = (k < NI);
        end
        rand_start = 1'b0;
    endtask

    task automatic plan_time();
        int t = 1;
        exp_stalls = 0;
        for (int n = 0; n < NH; n++) begin
            S[n] = t;
            A[n] = t + NI + s_cnt[n];
            R[n] = t + dly[n];
            // Row already present at the activation -> straight to layer 2.
            // Row arriving in the activation cycle -> one wait cycle.
            // Later -> layer 2 in the cycle after the arrival pulse.
            if (R[n] < A[n])       L2[n] = A[n] + 1;
            else if (R[n] == A[n]) L2[n] = A[n] + 2;
            else                   L2[n] = R[n] + 1;
            exp_stalls += s_cnt[n] + (L2[n] - A[n] - 1);
            t = L2[n] + 1;
        end
        t_out  = t;
        t_done = t + 1;
    endtask

    function automatic logic [OBS_W-1:0] model_out(input int t);
        logic b, d, m1c, m1e, a1, w2l, m2c, m2e, oa;
        int   ia, wa, hi;
        b = 0; d = 0; m1c = 0; m1e = 0; a1 = 0; w2l = 0; m2c = 0; m2e = 0; oa = 0;
        ia = 0; wa = idle_w1; hi = idle_hid;
        if (t == 0) begin
            m1c = 1; m2c = 1;
        end else if (t >= t_done) begin
            d = (t == t_done); wa = NH * NI; hi = NH - 1;
        end else if (t == t_out) begin
            b = 1; oa = 1; wa = NH * NI; hi = NH - 1;
        end else begin
            b = 1;
            for (int n = 0; n < NH; n++) begin
                if (t >= S[n] && t <= L2[n]) begin
                    hi = n;
                    if (t < A[n]) begin
                        int off;
                        int words;
                        off = t - S[n];
                        words = 0;
                        for (int k = 0; k < off; k++) words += int'(vplan[n][k]);
                        m1e = vplan[n][off];
                        w2l = (off == 0);
                        ia  = words;
                        wa  = n * NI + words;
                    end else begin
                        wa = (n + 1) * NI;
                        if (t == A[n]) a1 = 1;
                        if (t == L2[n]) begin
                            m2e = 1;
                            m1c = (n != NH - 1);
                        end
                    end
                end
            end
        end
        return {b, d, m1c, m1e, a1, w2l, m2c, m2e, oa, 10'(ia), AW'(wa), 8'(hi)};
    endfunction

    // Replays the current plan from the start cycle; abort_at >= 0 asserts
    // reset asynchronously in that cycle and checks the cleared outputs.
    task automatic run_inference(input int abort_at);
        logic [OBS_W-1:0] e;
        int n_act = 0;
        int n_m2  = 0;
        plan_time();
        for (int t = 0; t <= t_done + 2; t++) begin
            @(negedge clk);
            start = (t == 0) || (rand_start && t >= 1 && t <= t_out && $urandom_range(0, 3) == 0);
            w1_valid = 1'($urandom_range(0, 1));
            w2_row_ready = (t == 0 || t >= t_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int n = 0; n < NH; n++) begin
                if (t >= S[n] && t < A[n]) w1_valid = vplan[n][t - S[n]];
                if (t == R[n] || (dup_en[n] && t == R[n] + 1 && R[n] + 1 <= A[n]))
                    w2_row_ready = 1'b1;
            end
            #1;
            e = model_out(t);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL cycle_%0d outputs: got %h expected %h", t, obs, e);
            end
            if (act1_en === 1'b1) n_act++;
            if (mac2_en === 1'b1) n_m2++;
`ifdef NNSEQ_PERF_CNT_EN
            if (t > t_done) begin
                vectors++;
                if (stall_cycles !== 32'(exp_stalls)) begin
                    miscompares++;
                    $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls);
                end
            end
`endif
            if (t == abort_at) begin
                #1 reset = 1'b1;
                start = 1'b0;
                w1_valid = 1'b1;
                #1;
                vectors++;
                if (obs !== '0) begin
                    miscompares++;
                    $display("FAIL reset_async: got %h expected 0", obs);
                end
`ifdef NNSEQ_PERF_CNT_EN
                vectors++;
                if (stall_cycles !== 32'd0) begin
                    miscompares++;
                    $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
                end
`endif
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (c == 3) reset = 1'b0;
                    start = 1'b0;
                    w1_valid = 1'b1;
                    w2_row_ready = 1'b0;
                    #1;
                    vectors++;
                    if (obs !== '0) begin
                        miscompares++;
                        $display("FAIL reset_hold_%0d: got %h expected 0", c, obs);
                    end
                end
                idle_w1  = 0;
                idle_hid = 0;
                return;
            end
        end
        vectors++;
        if (n_act != NH) begin
            miscompares++;
            $display("FAIL act1_en_count: got %0d expected %0d", n_act, NH);
        end
        vectors++;
        if (n_m2 != NH) begin
            miscompares++;
            $display("FAIL mac2_en_count: got %0d expected %0d", n_m2, NH);
        end
        idle_w1  = NH * NI;
        idle_hid = NH - 1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h expected 0", obs);
        end
    endtask

    task automatic test_no_stall();
        plan_clear();
        run_inference(-1);
    endtask

    task automatic test_w1_stall();
        // Neuron 0 stalls in absolute cycles 5..9: in_addr holds at 4.
        plan_clear();
        s_cnt[0] = 5;
        for (int k = 0; k < MAXL; k++) vplan[0][k] = (k < NI + 5) && !(k >= 4 && k <= 8);
        run_inference(-1);
    endtask

    task automatic test_late_w2();
        // Neuron 3's row arrives 20 cycles after its activation.
        plan_clear();
        dly[3] = NI + 20;
        run_inference(-1);
    endtask

    task automatic test_reset_mid();
        plan_clear();
        plan_time();
        run_inference(S[3] + NI / 2);
        plan_clear();
        run_inference(-1);
    endtask

    task automatic test_protocol_edges();
        plan_clear();
        rand_start = 1'b1;
        for (int n = 0; n < NH; n++) dup_en[n] = 1'b1;
        run_inference(-1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            plan_clear();
            rand_start = 1'($urandom_range(0, 1));
            for (int n = 0; n < NH; n++) begin
                int len;
                int k;
                s_cnt[n] = $urandom_range(0, 3);
                len = NI + s_cnt[n];
                for (int q = 0; q < MAXL; q++) vplan[n][q] = (q < len);
                k = 0;
                while (k < s_cnt[n]) begin
                    int p;
                    p = $urandom_range(0, len - 2);
                    if (vplan[n][p]) begin
                        vplan[n][p] = 1'b0;
                        k++;
                    end
                end
                dly[n]    = $urandom_range(1, NI + 8);
                dup_en[n] = 1'($urandom_range(0, 1));
            end
            run_inference(-1);
        end
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_w1_stall();
        test_late_w2();
        test_reset_mid();
        test_protocol_edges();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
